exmem_stage_reg: RTL and testbench
==================================

Name: exmem_stage_reg

Overview:
- Parametrised EX/MEM pipeline register with valid/ready flow control, an optional skid buffer, flush/bubble insertion and a stall-cycle counter.
- Sits between the execute stage (ALU result, store data, destination register, control bits) and the memory stage.
- Allows memory-side back-pressure without a combinational ready path into EX, and allows branch/exception flush.

Parameters:
- XLEN, 32, width of PC, IR, ALU result and RS2 store data.
- REG_AW, 5, width of destination register address.
- CTRL_W, 5, control bundle width; bit order [0] mem_read, [1] mem_to_reg, [2] pc_to_reg, [3] mem_write, [4] reg_write, higher bits user-defined.
- SKID, 1, 1 = two-entry (main + skid) registered-ready stage; 0 = single register with combinational ready.
- CNT_W, 16, stall counter width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- in_pc, in_ir, in_alu_res, in_rs2  in  XLEN each  EX payload
- in_wr_addr  in  REG_AW  destination register
- in_ctrl  in  CTRL_W  control bundle
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM stage consumes this cycle
- out_pc, out_ir, out_alu_res, out_rs2  out  XLEN each  registered payload
- out_wr_addr  out  REG_AW  registered destination
- out_ctrl  out  CTRL_W  stored ctrl ANDed with out_valid
- stall_cnt  out  CNT_W  cycles with out_valid & ~out_ready

Behaviour:
- Reset (reset==0 at posedge):
  - main and skid valid are cleared; all payload registers are 0.
  - stall_cnt is 0; in_ready is 1 in the cycle after reset when SKID=1.
  - Reset has priority over flush and over both handshakes.
- Handshakes:
  - Accept when in_valid & in_ready.
  - Emit when out_valid & out_ready.
  - Latency in to out is exactly 1 cycle; sustained throughput is 1 per cycle while out_ready=1.
- SKID=1:
  - in_ready is registered and equals ~skid_valid.
  - Accept with main empty, or main emitting this cycle: the entry goes to main.
  - Accept with main full and not emitting: the entry goes to skid.
  - Emit while skid full: skid moves to main and skid_valid clears. A simultaneous accept cannot occur, since in_ready=0.
  - Emit with main full, skid empty and no accept: main_valid clears.
  - No entry is ever dropped or duplicated; order is preserved.
- SKID=0:
  - in_ready = ~out_valid | out_ready, combinational; there is no skid register.
- Flush:
  - Clears main_valid and skid_valid at the edge.
  - An entry accepted in the same cycle is discarded.
  - in_ready=1 the following cycle.
  - Payload registers are not cleared.
- Bubble:
  - When out_valid=0, out_ctrl is all zeros (no reg_write/mem_write side effects).
  - Data outputs hold their last value.
- stall_cnt:
  - Increments by 1 on each cycle with out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W-1 and is cleared only by reset.
- All outputs except in_ready (SKID=0) and the out_ctrl gating are direct register outputs.

Test Plan:
- Reset then stream: reset=0 for 2 cycles, then in_valid=1 with alu_res 0x10,0x11,0x12 and out_ready=1 -> out_valid rises 1 cycle after the first accept; outputs 0x10,0x11,0x12 on consecutive cycles; stall_cnt=0.
- Back-pressure (SKID=1): stream 0xA0..0xA3 with out_ready=0 for 3 cycles from the second output cycle -> main holds 0xA0, skid holds 0xA1, in_ready=0; after release outputs are 0xA0,0xA1,0xA2,0xA3 in order; stall_cnt=3.
- Flush with skid full: main=0xB0, skid=0xB1, assert flush with in_valid=1, in_alu_res=0xB2 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 0xB2 is never emitted.
- Bubble ctrl gating: in_ctrl=5'b11111 accepted and consumed, then in_valid=0 -> out_valid=0 and out_ctrl=5'b00000 while out_alu_res keeps its last value.
- SKID=0 build: out_valid=1, out_ready=0 -> in_ready=0 combinationally; out_ready=1 in the same cycle -> in_ready=1 and the new entry replaces the old one at the edge.
- Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt stops at 15; reset=0 -> stall_cnt=0.

Source files
------------

// File: rtl/exmem_stage_reg.sv
// EX/MEM pipeline register with valid/ready flow control, optional skid entry,
// flush, bubble ctrl gating and a saturating stall-cycle counter.
module exmem_stage_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_ir,
    input  logic [XLEN-1:0]   in_alu_res,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [REG_AW-1:0] in_wr_addr,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_ir,
    output logic [XLEN-1:0]   out_alu_res,
    output logic [XLEN-1:0]   out_rs2,
    output logic [REG_AW-1:0] out_wr_addr,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PW = 4*XLEN + REG_AW + CTRL_W;

    logic [PW-1:0]     in_bus;
    logic [PW-1:0]     main_q, main_d;
    logic [PW-1:0]     skid_q, skid_d;
    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic              accept, emit;

    assign in_bus = {in_pc, in_ir, in_alu_res, in_rs2, in_wr_addr, in_ctrl};

    // Without the skid entry, ready must look through to the consumer.
    assign in_ready = (SKID != 0) ? in_ready_q : (~main_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign emit     = main_valid_q & out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (emit && skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!main_valid_q || emit)) begin
            main_d       = in_bus;
            main_valid_d = 1'b1;
        end else if (accept) begin
            skid_d       = in_bus;
            skid_valid_d = 1'b1;
        end else if (emit) begin
            main_valid_d = 1'b0;
        end
        in_ready_d = ~skid_valid_d;

        stall_d = stall_q;
        if (main_valid_q && !out_ready && !flush && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            stall_q      <= '0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            stall_q      <= stall_d;
        end
    end

    assign {out_pc, out_ir, out_alu_res, out_rs2, out_wr_addr, ctrl_q} = main_q;
    assign out_valid = main_valid_q;
    assign out_ctrl  = ctrl_q & {CTRL_W{main_valid_q}};
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_exmem_stage_reg.sv
// Bench for exmem_stage_reg: a SKID=1 instance and a SKID=0/CNT_W=4 instance
// share stimulus; directed vector tables plus a queue-based reference model.
module tb_exmem_stage_reg;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_pc = '0, in_ir = '0, in_alu_res = '0, in_rs2 = '0;
    logic [4:0]  in_wr_addr = '0, in_ctrl = '0;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_pc, a_ir, a_alu, a_rs2;
    logic [4:0]  a_wa, a_ctrl;
    logic [15:0] a_stall;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_pc, b_ir, b_alu, b_rs2;
    logic [4:0]  b_wa, b_ctrl;
    logic [3:0]  b_stall;

    always #5 clock = ~clock;

    exmem_stage_reg #(.SKID(1), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .in_alu_res(in_alu_res), .in_rs2(in_rs2),
        .in_wr_addr(in_wr_addr), .in_ctrl(in_ctrl),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .out_ir(a_ir), .out_alu_res(a_alu), .out_rs2(a_rs2),
        .out_wr_addr(a_wa), .out_ctrl(a_ctrl), .stall_cnt(a_stall)
    );

    exmem_stage_reg #(.SKID(0), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_pc(in_pc), .in_ir(in_ir), .in_alu_res(in_alu_res), .in_rs2(in_rs2),
        .in_wr_addr(in_wr_addr), .in_ctrl(in_ctrl),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .out_ir(b_ir), .out_alu_res(b_alu), .out_rs2(b_rs2),
        .out_wr_addr(b_wa), .out_ctrl(b_ctrl), .stall_cnt(b_stall)
    );

    typedef struct packed {
        logic [31:0] pc, ir, alu, rs2;
        logic [4:0]  wa, ctrl;
    } ent_t;

    // Reference: each instance is a bounded FIFO (depth 2 / depth 1); the
    // output payload is the head, or the last head once the FIFO drains.
    ent_t        qa[$], qb[$];
    ent_t        la, lb;
    int unsigned sa, sb;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic bit rdy_a();
        return qa.size() < 2;
    endfunction

    function automatic bit rdy_b();
        return (qb.size() == 0) || out_ready;
    endfunction

    task automatic model_step();
        ent_t e;
        bit   acc_a, acc_b, em_a, em_b;
        e = '{in_pc, in_ir, in_alu_res, in_rs2, in_wr_addr, in_ctrl};
        if (!reset) begin
            qa.delete(); qb.delete();
            la = '0; lb = '0; sa = 0; sb = 0;
            return;
        end
        acc_a = in_valid && rdy_a();
        acc_b = in_valid && rdy_b();
        em_a  = (qa.size() > 0) && out_ready;
        em_b  = (qb.size() > 0) && out_ready;
        if (qa.size() > 0 && !out_ready && !flush && sa < 65535) sa++;
        if (qb.size() > 0 && !out_ready && !flush && sb < 15) sb++;
        if (flush) begin
            qa.delete(); qb.delete();
        end else begin
            if (em_a) void'(qa.pop_front());
            if (acc_a) qa.push_back(e);
            if (em_b) void'(qb.pop_front());
            if (acc_b) qb.push_back(e);
        end
        if (qa.size() > 0) la = qa[0];
        if (qb.size() > 0) lb = qb[0];
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic check_all();
        bit va, vb;
        va = qa.size() > 0;
        vb = qb.size() > 0;
        chk("a_out_valid", a_out_valid, va);
        chk("a_in_ready", a_in_ready, rdy_a());
        chk("a_stall", a_stall, sa);
        chk("a_pc", a_pc, la.pc);
        chk("a_ir", a_ir, la.ir);
        chk("a_alu", a_alu, la.alu);
        chk("a_rs2", a_rs2, la.rs2);
        chk("a_wa", a_wa, la.wa);
        chk("a_ctrl", a_ctrl, va ? la.ctrl : 5'd0);
        chk("b_out_valid", b_out_valid, vb);
        chk("b_in_ready", b_in_ready, rdy_b());
        chk("b_stall", b_stall, sb);
        chk("b_pc", b_pc, lb.pc);
        chk("b_alu", b_alu, lb.alu);
        chk("b_rs2", b_rs2, lb.rs2);
        chk("b_wa", b_wa, lb.wa);
        chk("b_ctrl", b_ctrl, vb ? lb.ctrl : 5'd0);
    endtask

    task automatic drive(input bit v, input bit ordy, input bit fl, input logic [31:0] alu,
                         input logic [4:0] ctrl);
        in_valid   = v;
        out_ready  = ordy;
        flush      = fl;
        in_alu_res = alu;
        in_ctrl    = ctrl;
        in_pc      = alu ^ 32'h1000;
        in_ir      = ~alu;
        in_rs2     = alu + 32'd7;
        in_wr_addr = alu[4:0];
    endtask

    typedef struct {
        bit          rst_n, v, ordy, fl;
        logic [31:0] alu;
        logic [4:0]  ctrl;
        bit          e_ov, e_ir;
        logic [31:0] e_alu;
        logic [4:0]  e_ctrl;
        int          e_stall;
    } vec_t;

    function automatic vec_t mk(bit r, bit v, bit o, bit f, logic [31:0] alu, logic [4:0] c,
                                bit eov, bit eir, logic [31:0] ealu, logic [4:0] ec, int es);
        vec_t t;
        t = '{r, v, o, f, alu, c, eov, eir, ealu, ec, es};
        return t;
    endfunction

    vec_t tv[$];

    initial begin
        // rst  v  or fl  alu      ctrl     ov ir e_alu    e_ctrl  stall
        tv.push_back(mk(0, 0, 1, 0, 32'h00, 5'h00,  0, 1, 32'h00, 5'h00, 0));
        tv.push_back(mk(0, 0, 1, 0, 32'h00, 5'h00,  0, 1, 32'h00, 5'h00, 0));
        tv.push_back(mk(1, 1, 1, 0, 32'h10, 5'h15,  1, 1, 32'h10, 5'h15, 0));
        tv.push_back(mk(1, 1, 1, 0, 32'h11, 5'h15,  1, 1, 32'h11, 5'h15, 0));
        tv.push_back(mk(1, 1, 1, 0, 32'h12, 5'h15,  1, 1, 32'h12, 5'h15, 0));
        tv.push_back(mk(1, 0, 1, 0, 32'h00, 5'h15,  0, 1, 32'h12, 5'h00, 0));
        // back-pressure: A1 lands in skid, A2 is held off by in_ready=0
        tv.push_back(mk(1, 1, 1, 0, 32'hA0, 5'h0A,  1, 1, 32'hA0, 5'h0A, 0));
        tv.push_back(mk(1, 1, 0, 0, 32'hA1, 5'h0A,  1, 0, 32'hA0, 5'h0A, 1));
        tv.push_back(mk(1, 1, 0, 0, 32'hA2, 5'h0A,  1, 0, 32'hA0, 5'h0A, 2));
        tv.push_back(mk(1, 1, 0, 0, 32'hA2, 5'h0A,  1, 0, 32'hA0, 5'h0A, 3));
        tv.push_back(mk(1, 1, 1, 0, 32'hA2, 5'h0A,  1, 1, 32'hA1, 5'h0A, 3));
        tv.push_back(mk(1, 1, 1, 0, 32'hA2, 5'h0A,  1, 1, 32'hA2, 5'h0A, 3));
        tv.push_back(mk(1, 1, 1, 0, 32'hA3, 5'h0A,  1, 1, 32'hA3, 5'h0A, 3));
        tv.push_back(mk(1, 0, 1, 0, 32'hA3, 5'h0A,  0, 1, 32'hA3, 5'h00, 3));
        // flush with skid full; payload keeps B0, B2 never appears
        tv.push_back(mk(1, 1, 1, 0, 32'hB0, 5'h13,  1, 1, 32'hB0, 5'h13, 3));
        tv.push_back(mk(1, 1, 0, 0, 32'hB1, 5'h13,  1, 0, 32'hB0, 5'h13, 4));
        tv.push_back(mk(1, 1, 0, 1, 32'hB2, 5'h13,  0, 1, 32'hB0, 5'h00, 4));
        tv.push_back(mk(1, 0, 1, 0, 32'hB2, 5'h13,  0, 1, 32'hB0, 5'h00, 4));
        // bubble gating of ctrl
        tv.push_back(mk(1, 1, 1, 0, 32'hC0, 5'h1F,  1, 1, 32'hC0, 5'h1F, 4));
        tv.push_back(mk(1, 0, 1, 0, 32'hC0, 5'h1F,  0, 1, 32'hC0, 5'h00, 4));

        la = '0; lb = '0; sa = 0; sb = 0;
        @(negedge clock);

        foreach (tv[i]) begin
            reset = tv[i].rst_n;
            drive(tv[i].v, tv[i].ordy, tv[i].fl, tv[i].alu, tv[i].ctrl);
            tick();
            chk($sformatf("vec%0d_out_valid", i), a_out_valid, tv[i].e_ov);
            chk($sformatf("vec%0d_in_ready", i), a_in_ready, tv[i].e_ir);
            chk($sformatf("vec%0d_alu", i), a_alu, tv[i].e_alu);
            chk($sformatf("vec%0d_ctrl", i), a_ctrl, tv[i].e_ctrl);
            chk($sformatf("vec%0d_stall", i), a_stall, tv[i].e_stall);
            check_all();
        end

        // SKID=0: ready follows out_ready combinationally, replace at the edge
        drive(1, 0, 0, 32'hD0, 5'h07);
        tick();
        check_all();
        chk("b_holds_d0", b_alu, 32'hD0);
        drive(1, 0, 0, 32'hD1, 5'h07);
        #1;
        chk("b_in_ready_blocked", b_in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("b_in_ready_through", b_in_ready, 1'b1);
        tick();
        chk("b_replaced_valid", b_out_valid, 1'b1);
        chk("b_replaced_alu", b_alu, 32'hD1);
        check_all();
        drive(0, 1, 0, 32'h0, 5'h0);
        tick();
        tick();
        check_all();

        // CNT_W=4 saturation, then reset clears
        drive(1, 1, 0, 32'hE0, 5'h01);
        tick();
        drive(0, 0, 0, 32'h0, 5'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all();
        end
        chk("b_stall_saturated", b_stall, 4'd15);
        reset = 1'b0;
        tick();
        chk("b_stall_after_reset", b_stall, 4'd0);
        chk("a_stall_after_reset", a_stall, 16'd0);
        chk("a_ready_after_reset", a_in_ready, 1'b1);
        check_all();
        reset = 1'b1;

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) != 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 24) == 0);
            in_pc      = $urandom;
            in_ir      = $urandom;
            in_alu_res = $urandom;
            in_rs2     = $urandom;
            in_wr_addr = 5'($urandom);
            in_ctrl    = 5'($urandom);
            tick();
            check_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
